// File: rtl/panda_pkg.sv
// Shared constants, FSM state types and helpers for the panda UART peripheral.
package panda_pkg;

    localparam logic [3:0] UART_TXDATA_OFFSET = 4'h0;
    localparam logic [3:0] UART_RXDATA_OFFSET = 4'h4;
    localparam logic [3:0] UART_STATUS_OFFSET = 4'h8;
    localparam logic [3:0] UART_DIV_OFFSET    = 4'hC;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } uart_tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } uart_rx_state_e;

    // A divisor below 2 would leave no room for the half-bit start check.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div < 16'd2) ? 16'd2 : div;
    endfunction

endpackage

// File: rtl/panda_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is visible combinationally on rdata.
module panda_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A push into a full FIFO is accepted only if the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem_reg[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_reg[wr_ptr_reg[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/panda_uart.sv
// Memory-mapped 8N1 UART: TX FIFO + shifter, synchronised RX shifter with one-byte
// holding register, programmable divisor and a registered level interrupt.
module panda_uart
    import panda_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          TX_DEPTH    = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [3:0]  data_we_i,
    output logic [31:0] data_rdata_o,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    output logic        irq_o
);

    logic        sel;
    logic        wr_en;
    logic [3:0]  reg_off;
    logic        tx_wr;
    logic        push_req;
    logic        rx_pop;
    logic        status_wr;
    logic        div_wr;
    logic        unused_bits;

    logic [15:0] div_reg;
    logic [15:0] div_eff;

    logic        fifo_pop;
    logic [7:0]  fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;

    uart_tx_state_e tx_state_reg, tx_state_next;
    logic [15:0] tx_cnt_reg, tx_cnt_next;
    logic [7:0]  tx_shift_reg, tx_shift_next;
    logic [2:0]  tx_bit_reg, tx_bit_next;
    logic        tx_line_reg, tx_line_next;
    logic        tx_busy;
    logic        tx_ovf_reg, tx_ovf_next;

    logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
    uart_rx_state_e rx_state_reg, rx_state_next;
    logic [15:0] rx_cnt_reg, rx_cnt_next;
    logic [7:0]  rx_shift_reg, rx_shift_next;
    logic [2:0]  rx_bit_reg, rx_bit_next;
    logic        rx_done;
    logic [7:0]  rx_byte_reg, rx_byte_next;
    logic        rx_valid_reg, rx_valid_next;
    logic        rx_ovf_reg, rx_ovf_next;

    logic        idle_empty;
    logic        idle_empty_prev_reg;
    logic        pend_reg, pend_next;
    logic        irq_reg;

    // ---------------- bus decode ----------------
    assign sel       = (data_addr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_off   = {data_addr_i[3:2], 2'b00};
    assign wr_en     = sel && (|data_we_i);
    assign tx_wr     = wr_en && (reg_off == UART_TXDATA_OFFSET);
    assign push_req  = tx_wr && data_we_i[0];
    assign rx_pop    = wr_en && (reg_off == UART_RXDATA_OFFSET);
    assign status_wr = wr_en && (reg_off == UART_STATUS_OFFSET) && data_we_i[0];
    assign div_wr    = wr_en && (reg_off == UART_DIV_OFFSET) && (data_we_i[1:0] == 2'b11);
    assign unused_bits = ^{data_wdata_i[31:16], data_addr_i[1:0]};

    assign div_eff = eff_div(div_reg);
    assign tx_busy = (tx_state_reg != TX_IDLE);

    always_comb begin
        data_rdata_o = '0;
        if (sel) begin
            case (reg_off)
                UART_RXDATA_OFFSET: data_rdata_o = {23'b0, rx_valid_reg, rx_byte_reg};
                UART_STATUS_OFFSET: data_rdata_o = {26'b0, tx_ovf_reg, rx_ovf_reg, rx_valid_reg,
                                                    tx_busy, fifo_full, fifo_empty};
                UART_DIV_OFFSET:    data_rdata_o = {16'b0, div_reg};
                default:            data_rdata_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     div_reg <= DEFAULT_DIV;
        else if (div_wr) div_reg <= data_wdata_i[15:0];
    end

    // ---------------- transmit path ----------------
    panda_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (push_req),
        .wdata (data_wdata_i[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = (tx_cnt_reg == '0) ? div_eff - 16'd1 : tx_cnt_reg - 16'd1;
        tx_shift_next = tx_shift_reg;
        tx_bit_next   = tx_bit_reg;
        tx_line_next  = tx_line_reg;
        fifo_pop      = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                tx_cnt_next = div_eff - 16'd1;
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    tx_shift_next = fifo_rdata;
                    tx_line_next  = 1'b0;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_reg == '0) begin
                    tx_line_next  = tx_shift_reg[0];
                    tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                    tx_bit_next   = 3'd0;
                    tx_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_reg == '0) begin
                    if (tx_bit_reg == 3'd7) begin
                        tx_line_next  = 1'b1;
                        tx_state_next = TX_STOP;
                    end else begin
                        tx_bit_next   = tx_bit_reg + 3'd1;
                        tx_line_next  = tx_shift_reg[0];
                        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                    end
                end
            end
            TX_STOP: begin
                // Chain straight into the next start bit when more data is queued.
                if (tx_cnt_reg == '0) begin
                    if (!fifo_empty) begin
                        fifo_pop      = 1'b1;
                        tx_shift_next = fifo_rdata;
                        tx_line_next  = 1'b0;
                        tx_state_next = TX_START;
                    end else begin
                        tx_state_next = TX_IDLE;
                    end
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    assign tx_ovf_next = (push_req && fifo_full && !fifo_pop) ||
                         (tx_ovf_reg && !(status_wr && data_wdata_i[5]));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_shift_reg <= '0;
            tx_bit_reg   <= '0;
            tx_line_reg  <= 1'b1;
            tx_ovf_reg   <= 1'b0;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_shift_reg <= tx_shift_next;
            tx_bit_reg   <= tx_bit_next;
            tx_line_reg  <= tx_line_next;
            tx_ovf_reg   <= tx_ovf_next;
        end
    end

    assign uart_tx_o = tx_line_reg;

    // ---------------- receive path ----------------
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = (rx_cnt_reg == '0) ? div_eff - 16'd1 : rx_cnt_reg - 16'd1;
        rx_shift_next = rx_shift_reg;
        rx_bit_next   = rx_bit_reg;
        rx_done       = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                rx_cnt_next = (div_eff >> 1) - 16'd1;
                if (rx_prev_reg && !rx_sync_reg) rx_state_next = RX_START;
            end
            RX_START: begin
                if (rx_cnt_reg == '0) begin
                    rx_bit_next   = 3'd0;
                    rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_reg == '0) begin
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
                    rx_bit_next   = rx_bit_reg + 3'd1;
                    if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_reg == '0) begin
                    rx_done       = rx_sync_reg;
                    rx_state_next = RX_IDLE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    // A completing frame beats a simultaneous pop; an unpopped byte is never overwritten.
    always_comb begin
        rx_byte_next  = rx_byte_reg;
        rx_valid_next = rx_valid_reg;
        rx_ovf_next   = rx_ovf_reg && !(status_wr && data_wdata_i[4]);
        if (rx_done && (!rx_valid_reg || rx_pop)) begin
            rx_byte_next  = rx_shift_reg;
            rx_valid_next = 1'b1;
        end else if (rx_done) begin
            rx_ovf_next   = 1'b1;
        end else if (rx_pop) begin
            rx_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_shift_reg <= '0;
            rx_bit_reg   <= '0;
            rx_byte_reg  <= '0;
            rx_valid_reg <= 1'b0;
            rx_ovf_reg   <= 1'b0;
        end else begin
            rx_meta_reg  <= uart_rx_i;
            rx_sync_reg  <= rx_meta_reg;
            rx_prev_reg  <= rx_sync_reg;
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_shift_reg <= rx_shift_next;
            rx_bit_reg   <= rx_bit_next;
            rx_byte_reg  <= rx_byte_next;
            rx_valid_reg <= rx_valid_next;
            rx_ovf_reg   <= rx_ovf_next;
        end
    end

    // ---------------- interrupt ----------------
    // "Transmission complete" is the moment the transmitter goes idle with nothing queued.
    assign idle_empty = fifo_empty && !tx_busy;

    always_comb begin
        pend_next = pend_reg;
        if (tx_wr)                                    pend_next = 1'b0;
        else if (idle_empty && !idle_empty_prev_reg)  pend_next = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_empty_prev_reg <= 1'b1;
            pend_reg            <= 1'b0;
            irq_reg             <= 1'b0;
        end else begin
            idle_empty_prev_reg <= idle_empty;
            pend_reg            <= pend_next;
            irq_reg             <= rx_valid_reg | pend_reg;
        end
    end

    assign irq_o = irq_reg;

endmodule
